uc_multicycle: RTL and testbench
================================

Name: uc_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle control unit. It sequences each instruction through FETCH/DECODE/EXEC/WAIT_ALU/WB with a valid/ready fetch handshake. It stalls on multi-cycle ALU ops, sequences PUSH/POP against stack status, and traps on illegal opcodes or stack faults. It sits between instruction memory and the datapath (ALU, register file, PC unit, stack).

Parameters:
IW, 32, instruction width
OPW, 6, opcode width; opcode = instruction[IW-1 -: OPW]
REGW, 3, op1 register-index width
STACK_EN, 1, 0 makes PUSH/POP illegal (trap cause 1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word valid
instr_ready  out  1  unit accepts instruction; high only in FETCH
instruction  in  IW  instruction word
alu_done  in  1  multi-cycle ALU result ready
stack_full  in  1  stack cannot accept push
stack_empty  in  1  stack has no entry to pop
alu_start  out  1  one-cycle pulse starting a multi-cycle ALU op
op1  out  REGW  latched instruction[IW-OPW-2 -: REGW]
op2  out  IW-OPW-REGW-2  latched low field (21 bits at default)
flag  out  1  latched instruction[IW-OPW-1]
flag1  out  1  latched bit just below op1
alucode  out  6  ALU function
im_control  out  1  1 = op2 is immediate
write_en  out  1  register-file write strobe
pc_control  out  5  PC mode
pc_update  out  1  PC commit strobe
stack_select  out  2  0 none, 1 push, 2 pop
halted  out  1  sticky HLT reached
trap  out  1  sticky fault
trap_cause  out  2  1 illegal opcode, 2 push-full, 3 pop-empty

Behaviour:
- Opcodes: ADD0 SUB1 MUL2 DIV3 ADDI4 SUBI5 MULI6 DIVI7 NOT8 AND9 OR10 XOR11 MOD12 SL13 SR14 JMP15 JE16 JB17 JA18 JNE19 JBE20 JAE21 JZ22 JNZ23 MOV24 NOP25 HLT26 PUSH27 POP28 MOVI29. Opcodes 30..2^OPW-1 are illegal.
- alucode: none0 ADD1 SUB2 MUL3 DIV4 MOD5 OR6 AND7 SL8 NOT9 SR10 XOR11. The I-forms share the base code and set im_control=1. MOVI sets im_control=1.
- pc_control: seq0 JE1 JB2 JA3 JNE4 JBE5 JAE6 JNZ7 JZ8 JMP9 HLT10.
- Reset (async, any state): state=FETCH; instruction register = 0. All outputs 0 except instr_ready=1.
- FETCH: instr_ready=1. On instr_valid&&instr_ready, latch instruction; next state DECODE.
- DECODE (1 cycle): register the field outputs (op1/op2/flag/flag1) and the control bundle.
  - Illegal opcode -> TRAP, cause 1.
  - Control outputs stay 0 during FETCH/DECODE.
- EXEC: alucode, im_control, pc_control are valid and held through WB.
  - MUL/DIV/MOD/MULI/DIVI: pulse alu_start, go to WAIT_ALU.
  - PUSH: if stack_full -> TRAP cause 2; else stack_select=1 for this cycle -> WB.
  - POP: if stack_empty -> TRAP cause 3; else stack_select=2 for this cycle -> WB.
  - HLT -> HALT.
  - All others -> WB.
- WAIT_ALU: hold outputs until alu_done=1, then WB. alu_done arriving in EXEC is ignored.
- WB (1 cycle): pc_update=1.
  - write_en=1 for ALU ops, MOV, MOVI, POP.
  - JMP/Jcc/NOP/PUSH leave write_en=0.
  - Next state FETCH; all control outputs return to 0.
- Latency: single-cycle ops take 4 cycles from handshake to next instr_ready; multi-cycle ops take 4 + alu_done wait.
- HALT: halted=1, instr_ready=0. Sticky until reset.
- TRAP: trap=1 with trap_cause held, instr_ready=0. Sticky until reset. write_en, pc_update and stack_select are never asserted for a faulting instruction.
- Fault priority: illegal opcode (DECODE) precedes stack checks (EXEC).

Decomposition:
- Package uc_pkg: opcode, alucode, pc_control, stack_select and trap-cause localparams; state encoding; control-bundle struct {alucode, im_control, writes, pc_control, stack_op, multicycle, illegal}.
- Sub-module uc_decode: combinational opcode -> control bundle, honouring STACK_EN.
- The top module holds the FSM, instruction register and output registers.

Test Plan:
- ADD (opcode 0, op1=3, op2=5): handshake at t -> alucode=1, im_control=0 at t+2..t+3; write_en and pc_update pulse at t+3; instr_ready=1 at t+4.
- DIVI with alu_done after 5 EXEC/WAIT cycles -> alu_start single pulse at t+2; alucode=4, im_control=1 held; WB exactly one cycle after alu_done.
- JZ -> pc_control=8, write_en=0, pc_update=1 in WB. JMP -> pc_control=9.
- PUSH with stack_full=1 -> trap=1, trap_cause=2, stack_select never 1. POP with stack_empty=0 -> stack_select=2 one cycle, then write_en=1.
- Opcode 31 -> trap_cause=1. HLT -> halted=1, instr_ready stays 0 for 20 cycles with instr_valid=1.
- reset_n low mid-WAIT_ALU -> all outputs 0 immediately, instr_ready=1. After release, NOP executes normally; STACK_EN=0 with PUSH -> trap_cause=1.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, control codes,
// FSM states and the decoded control bundle.
package uc_pkg;

  localparam int unsigned OpAdd  = 0;
  localparam int unsigned OpSub  = 1;
  localparam int unsigned OpMul  = 2;
  localparam int unsigned OpDiv  = 3;
  localparam int unsigned OpAddi = 4;
  localparam int unsigned OpSubi = 5;
  localparam int unsigned OpMuli = 6;
  localparam int unsigned OpDivi = 7;
  localparam int unsigned OpNot  = 8;
  localparam int unsigned OpAnd  = 9;
  localparam int unsigned OpOr   = 10;
  localparam int unsigned OpXor  = 11;
  localparam int unsigned OpMod  = 12;
  localparam int unsigned OpSl   = 13;
  localparam int unsigned OpSr   = 14;
  localparam int unsigned OpJmp  = 15;
  localparam int unsigned OpJe   = 16;
  localparam int unsigned OpJb   = 17;
  localparam int unsigned OpJa   = 18;
  localparam int unsigned OpJne  = 19;
  localparam int unsigned OpJbe  = 20;
  localparam int unsigned OpJae  = 21;
  localparam int unsigned OpJz   = 22;
  localparam int unsigned OpJnz  = 23;
  localparam int unsigned OpMov  = 24;
  localparam int unsigned OpNop  = 25;
  localparam int unsigned OpHlt  = 26;
  localparam int unsigned OpPush = 27;
  localparam int unsigned OpPop  = 28;
  localparam int unsigned OpMovi = 29;

  localparam logic [5:0] AluNone = 6'd0;
  localparam logic [5:0] AluAdd  = 6'd1;
  localparam logic [5:0] AluSub  = 6'd2;
  localparam logic [5:0] AluMul  = 6'd3;
  localparam logic [5:0] AluDiv  = 6'd4;
  localparam logic [5:0] AluMod  = 6'd5;
  localparam logic [5:0] AluOr   = 6'd6;
  localparam logic [5:0] AluAnd  = 6'd7;
  localparam logic [5:0] AluSl   = 6'd8;
  localparam logic [5:0] AluNot  = 6'd9;
  localparam logic [5:0] AluSr   = 6'd10;
  localparam logic [5:0] AluXor  = 6'd11;

  localparam logic [4:0] PcSeq = 5'd0;
  localparam logic [4:0] PcJe  = 5'd1;
  localparam logic [4:0] PcJb  = 5'd2;
  localparam logic [4:0] PcJa  = 5'd3;
  localparam logic [4:0] PcJne = 5'd4;
  localparam logic [4:0] PcJbe = 5'd5;
  localparam logic [4:0] PcJae = 5'd6;
  localparam logic [4:0] PcJnz = 5'd7;
  localparam logic [4:0] PcJz  = 5'd8;
  localparam logic [4:0] PcJmp = 5'd9;
  localparam logic [4:0] PcHlt = 5'd10;

  localparam logic [1:0] StkNone = 2'd0;
  localparam logic [1:0] StkPush = 2'd1;
  localparam logic [1:0] StkPop  = 2'd2;

  localparam logic [1:0] CauseNone      = 2'd0;
  localparam logic [1:0] CauseIllegal   = 2'd1;
  localparam logic [1:0] CausePushFull  = 2'd2;
  localparam logic [1:0] CausePopEmpty  = 2'd3;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StWaitAlu, StWb, StHalt, StTrap
  } state_e;

  typedef struct packed {
    logic [5:0] alucode;
    logic       im_control;
    logic       writes;
    logic [4:0] pc_control;
    logic [1:0] stack_op;
    logic       multicycle;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder producing the control bundle; PUSH/POP become
// illegal when the stack is not present.
module uc_decode
  import uc_pkg::*;
#(
  parameter int unsigned OPW      = 6,
  parameter bit          STACK_EN = 1'b1
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  logic [31:0] op_num;

  always_comb begin
    op_num = 32'(opcode);
    ctrl   = '0;
    case (op_num)
      OpAdd:  ctrl.alucode = AluAdd;
      OpSub:  ctrl.alucode = AluSub;
      OpMul:  begin ctrl.alucode = AluMul; ctrl.multicycle = 1'b1; end
      OpDiv:  begin ctrl.alucode = AluDiv; ctrl.multicycle = 1'b1; end
      OpAddi: begin ctrl.alucode = AluAdd; ctrl.im_control = 1'b1; end
      OpSubi: begin ctrl.alucode = AluSub; ctrl.im_control = 1'b1; end
      OpMuli: begin
        ctrl.alucode    = AluMul;
        ctrl.im_control = 1'b1;
        ctrl.multicycle = 1'b1;
      end
      OpDivi: begin
        ctrl.alucode    = AluDiv;
        ctrl.im_control = 1'b1;
        ctrl.multicycle = 1'b1;
      end
      OpNot:  ctrl.alucode = AluNot;
      OpAnd:  ctrl.alucode = AluAnd;
      OpOr:   ctrl.alucode = AluOr;
      OpXor:  ctrl.alucode = AluXor;
      OpMod:  begin ctrl.alucode = AluMod; ctrl.multicycle = 1'b1; end
      OpSl:   ctrl.alucode = AluSl;
      OpSr:   ctrl.alucode = AluSr;
      OpJmp:  ctrl.pc_control = PcJmp;
      OpJe:   ctrl.pc_control = PcJe;
      OpJb:   ctrl.pc_control = PcJb;
      OpJa:   ctrl.pc_control = PcJa;
      OpJne:  ctrl.pc_control = PcJne;
      OpJbe:  ctrl.pc_control = PcJbe;
      OpJae:  ctrl.pc_control = PcJae;
      OpJz:   ctrl.pc_control = PcJz;
      OpJnz:  ctrl.pc_control = PcJnz;
      OpMov, OpNop: ;
      OpHlt:  ctrl.pc_control = PcHlt;
      OpPush: begin
        if (STACK_EN) ctrl.stack_op = StkPush;
        else          ctrl.illegal  = 1'b1;
      end
      OpPop: begin
        if (STACK_EN) ctrl.stack_op = StkPop;
        else          ctrl.illegal  = 1'b1;
      end
      OpMovi: ctrl.im_control = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
    // Every ALU op writes back, plus the register moves and POP.
    ctrl.writes = (ctrl.alucode != AluNone) || (op_num == OpMov) || (op_num == OpMovi) ||
                  (ctrl.stack_op == StkPop);
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/WAIT_ALU/WB sequencer with a
// valid/ready fetch handshake, stack sequencing and sticky HALT/TRAP states.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int unsigned IW       = 32,
  parameter int unsigned OPW      = 6,
  parameter int unsigned REGW     = 3,
  parameter bit          STACK_EN = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [IW-1:0]             instruction,
  input  logic                      alu_done,
  input  logic                      stack_full,
  input  logic                      stack_empty,
  output logic                      alu_start,
  output logic [REGW-1:0]           op1,
  output logic [IW-OPW-REGW-3:0]    op2,
  output logic                      flag,
  output logic                      flag1,
  output logic [5:0]                alucode,
  output logic                      im_control,
  output logic                      write_en,
  output logic [4:0]                pc_control,
  output logic                      pc_update,
  output logic [1:0]                stack_select,
  output logic                      halted,
  output logic                      trap,
  output logic [1:0]                trap_cause
);

  state_e                  state_q, state_d;
  logic [1:0]              cause_q, cause_d;
  logic [IW-1:0]           ir_q;
  ctrl_t                   ctrl_q, dec;
  logic [REGW-1:0]         op1_q;
  logic [IW-OPW-REGW-3:0]  op2_q;
  logic                    flag_q, flag1_q;
  logic [OPW-1:0]          opcode;

  assign opcode = ir_q[IW-1 -: OPW];

  uc_decode #(
    .OPW      (OPW),
    .STACK_EN (STACK_EN)
  ) u_decode (
    .opcode (opcode),
    .ctrl   (dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StFetch: if (instr_valid) state_d = StDecode;
      StDecode: begin
        if (dec.illegal) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // The illegal guard is unreachable from DECODE; it keeps a corrupted bundle safe.
        if (ctrl_q.illegal) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else if (ctrl_q.multicycle) begin
          state_d = StWaitAlu;
        end else if (ctrl_q.stack_op == StkPush && stack_full) begin
          state_d = StTrap;
          cause_d = CausePushFull;
        end else if (ctrl_q.stack_op == StkPop && stack_empty) begin
          state_d = StTrap;
          cause_d = CausePopEmpty;
        end else if (ctrl_q.pc_control == PcHlt) begin
          state_d = StHalt;
        end else begin
          state_d = StWb;
        end
      end
      StWaitAlu: if (alu_done) state_d = StWb;
      StWb:      state_d = StFetch;
      StHalt, StTrap: ;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= '0;
      ctrl_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      flag_q  <= 1'b0;
      flag1_q <= 1'b0;
    end else begin
      if (state_q == StFetch && instr_valid) ir_q <= instruction;
      if (state_q == StDecode) begin
        ctrl_q  <= dec;
        op1_q   <= ir_q[IW-OPW-2 -: REGW];
        op2_q   <= ir_q[IW-OPW-REGW-3:0];
        flag_q  <= ir_q[IW-OPW-1];
        flag1_q <= ir_q[IW-OPW-2-REGW];
      end
    end
  end

  always_comb begin
    instr_ready  = 1'b0;
    alu_start    = 1'b0;
    alucode      = AluNone;
    im_control   = 1'b0;
    pc_control   = PcSeq;
    write_en     = 1'b0;
    pc_update    = 1'b0;
    stack_select = StkNone;
    halted       = 1'b0;
    trap         = 1'b0;
    case (state_q)
      StFetch: instr_ready = 1'b1;
      StExec: begin
        alucode    = ctrl_q.alucode;
        im_control = ctrl_q.im_control;
        pc_control = ctrl_q.pc_control;
        alu_start  = ctrl_q.multicycle;
        if (ctrl_q.stack_op == StkPush && !stack_full)      stack_select = StkPush;
        else if (ctrl_q.stack_op == StkPop && !stack_empty) stack_select = StkPop;
      end
      StWaitAlu: begin
        alucode    = ctrl_q.alucode;
        im_control = ctrl_q.im_control;
        pc_control = ctrl_q.pc_control;
      end
      StWb: begin
        alucode    = ctrl_q.alucode;
        im_control = ctrl_q.im_control;
        pc_control = ctrl_q.pc_control;
        write_en   = ctrl_q.writes;
        pc_update  = 1'b1;
      end
      StHalt:  halted = 1'b1;
      StTrap:  trap   = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = cause_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign flag       = flag_q;
  assign flag1      = flag1_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// Self-checking bench for uc_multicycle: directed scenarios then random
// instructions checked against an opcode-table reference model.
module tb_uc_multicycle;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        alu_done = 1'b0;
  logic        stack_full = 1'b0;
  logic        stack_empty = 1'b0;

  logic        a_ready, a_alu_start, a_flag, a_flag1, a_im, a_we, a_pcu, a_halted, a_trap;
  logic [2:0]  a_op1;
  logic [20:0] a_op2;
  logic [5:0]  a_alucode;
  logic [4:0]  a_pc;
  logic [1:0]  a_ss, a_cause;

  logic        b_ready, b_alu_start, b_flag, b_flag1, b_im, b_we, b_pcu, b_halted, b_trap;
  logic [2:0]  b_op1;
  logic [20:0] b_op2;
  logic [5:0]  b_alucode;
  logic [4:0]  b_pc;
  logic [1:0]  b_ss, b_cause;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  uc_multicycle u_dut (
    .clock (clock), .reset_n (reset_n), .instr_valid (instr_valid), .instr_ready (a_ready),
    .instruction (instruction), .alu_done (alu_done), .stack_full (stack_full),
    .stack_empty (stack_empty), .alu_start (a_alu_start), .op1 (a_op1), .op2 (a_op2),
    .flag (a_flag), .flag1 (a_flag1), .alucode (a_alucode), .im_control (a_im),
    .write_en (a_we), .pc_control (a_pc), .pc_update (a_pcu), .stack_select (a_ss),
    .halted (a_halted), .trap (a_trap), .trap_cause (a_cause)
  );

  uc_multicycle #(.STACK_EN(1'b0)) u_dut_nostk (
    .clock (clock), .reset_n (reset_n), .instr_valid (instr_valid), .instr_ready (b_ready),
    .instruction (instruction), .alu_done (alu_done), .stack_full (stack_full),
    .stack_empty (stack_empty), .alu_start (b_alu_start), .op1 (b_op1), .op2 (b_op2),
    .flag (b_flag), .flag1 (b_flag1), .alucode (b_alucode), .im_control (b_im),
    .write_en (b_we), .pc_control (b_pc), .pc_update (b_pcu), .stack_select (b_ss),
    .halted (b_halted), .trap (b_trap), .trap_cause (b_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: opcode tables straight from the instruction set definition.
  function automatic int unsigned m_alu(input int unsigned o);
    case (o)
      0, 4:    return 1;
      1, 5:    return 2;
      2, 6:    return 3;
      3, 7:    return 4;
      8:       return 9;
      9:       return 7;
      10:      return 6;
      11:      return 11;
      12:      return 5;
      13:      return 8;
      14:      return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned m_pc(input int unsigned o);
    case (o)
      15: return 9;  16: return 1;  17: return 2;  18: return 3;  19: return 4;
      20: return 5;  21: return 6;  22: return 8;  23: return 7;  26: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_im(input int unsigned o);
    return (o >= 4 && o <= 7) || o == 29;
  endfunction

  function automatic bit m_wr(input int unsigned o);
    return o <= 14 || o == 24 || o == 28 || o == 29;
  endfunction

  function automatic bit m_multi(input int unsigned o);
    return o == 2 || o == 3 || o == 6 || o == 7 || o == 12;
  endfunction

  task automatic do_reset();
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    alu_done    = 1'b0;
    #1;
    check("rst_ready", 32'(a_ready), 1);
    check("rst_halted", 32'(a_halted), 0);
    check("rst_trap", 32'(a_trap), 0);
    check("rst_cause", 32'(a_cause), 0);
    check("rst_alucode", 32'(a_alucode), 0);
    check("rst_pc", 32'(a_pc), 0);
    check("rst_im", 32'(a_im), 0);
    check("rst_we", 32'(a_we), 0);
    check("rst_pcu", 32'(a_pcu), 0);
    check("rst_ss", 32'(a_ss), 0);
    check("rst_alu_start", 32'(a_alu_start), 0);
    check("rst_fields", {8'd0, a_op2, a_op1}, 0);
    check("rst_flags", {30'd0, a_flag, a_flag1}, 0);
    check("rst_b_ready", 32'(b_ready), 1);
    check("rst_b_trap", 32'(b_trap), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] w, input bit sfull, input bit sempty,
                           input int wait_cyc, input bit early, output bit stuck);
    int unsigned o;
    int unsigned exp_ss;
    bit push, pop;
    o      = 32'(w[31:26]);
    push   = (o == 27);
    pop    = (o == 28);
    exp_ss = (push && !sfull) ? 1 : ((pop && !sempty) ? 2 : 0);
    stuck  = 1'b0;
    stack_full  = sfull;
    stack_empty = sempty;
    check("fetch_ready", 32'(a_ready), 1);
    instruction = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instruction = $urandom;
    check("dec_ready", 32'(a_ready), 0);
    check("dec_alucode", 32'(a_alucode), 0);
    check("dec_strobes", {29'd0, a_we, a_pcu, a_alu_start}, 0);
    step();
    if (o >= 30) begin
      check("ill_trap", 32'(a_trap), 1);
      check("ill_cause", 32'(a_cause), 1);
      check("ill_strobes", {27'd0, a_ss, a_we, a_pcu, a_ready}, 0);
      stuck = 1'b1;
      return;
    end
    check("ex_alucode", 32'(a_alucode), m_alu(o));
    check("ex_im", 32'(a_im), 32'(m_im(o)));
    check("ex_pc", 32'(a_pc), m_pc(o));
    check("ex_op1", 32'(a_op1), 32'(w[24:22]));
    check("ex_op2", 32'(a_op2), 32'(w[20:0]));
    check("ex_flags", {30'd0, a_flag, a_flag1}, {30'd0, w[25], w[21]});
    check("ex_alu_start", 32'(a_alu_start), 32'(m_multi(o)));
    check("ex_ss", 32'(a_ss), exp_ss);
    check("ex_we_pcu", {30'd0, a_we, a_pcu}, 0);
    if ((push && sfull) || (pop && sempty)) begin
      step();
      check("stk_trap", 32'(a_trap), 1);
      check("stk_cause", 32'(a_cause), push ? 2 : 3);
      check("stk_strobes", {27'd0, a_ss, a_we, a_pcu, a_ready}, 0);
      stuck = 1'b1;
      return;
    end
    if (o == 26) begin
      instr_valid = 1'b1;
      step();
      check("hlt_halted", 32'(a_halted), 1);
      for (int k = 0; k < 20; k++) begin
        check("hlt_ready", 32'(a_ready), 0);
        step();
      end
      check("hlt_sticky", 32'(a_halted), 1);
      instr_valid = 1'b0;
      stuck = 1'b1;
      return;
    end
    if (m_multi(o)) begin
      alu_done = early;
      step();
      alu_done = 1'b0;
      check("wait_alu_start", 32'(a_alu_start), 0);
      check("wait_we_pcu", {30'd0, a_we, a_pcu}, 0);
      for (int k = 0; k < wait_cyc; k++) begin
        step();
        check("wait_alucode", 32'(a_alucode), m_alu(o));
        check("wait_hold", {30'd0, a_we, a_pcu}, 0);
      end
      alu_done = 1'b1;
      step();
      alu_done = 1'b0;
    end else begin
      step();
    end
    check("wb_we", 32'(a_we), 32'(m_wr(o)));
    check("wb_pcu", 32'(a_pcu), 1);
    check("wb_alucode", 32'(a_alucode), m_alu(o));
    check("wb_im", 32'(a_im), 32'(m_im(o)));
    check("wb_pc", 32'(a_pc), m_pc(o));
    check("wb_ss", 32'(a_ss), 0);
    step();
    check("nxt_ready", 32'(a_ready), 1);
    check("nxt_idle", {19'd0, a_alucode, a_pc, a_im, a_we, a_pcu}, 0);
  endtask

  initial begin
    bit stuck;
    logic [31:0] w;
    int unsigned sel;
    #2;
    do_reset();

    run_instr({6'd0, 1'b0, 3'd3, 1'b0, 21'd5}, 1'b0, 1'b1, 0, 1'b0, stuck);   // ADD
    run_instr({6'd7, 26'($urandom)}, 1'b0, 1'b0, 4, 1'b1, stuck);            // DIVI
    run_instr({6'd22, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);           // JZ
    run_instr({6'd15, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);           // JMP
    run_instr({6'd27, 26'($urandom)}, 1'b1, 1'b0, 0, 1'b0, stuck);           // PUSH full
    do_reset();
    run_instr({6'd28, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);           // POP
    run_instr({6'd31, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);           // illegal
    do_reset();
    run_instr({6'd26, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);           // HLT
    do_reset();

    // Reset arriving while a DIV waits on the ALU.
    instruction = {6'd3, 26'($urandom)};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check("midrst_alu_start", 32'(a_alu_start), 1);
    step();
    check("midrst_wait_alucode", 32'(a_alucode), 4);
    do_reset();
    run_instr({6'd25, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);           // NOP

    // Stackless variant must treat PUSH as illegal.
    do_reset();
    run_instr({6'd27, 26'($urandom)}, 1'b0, 1'b0, 0, 1'b0, stuck);
    check("nostk_trap", 32'(b_trap), 1);
    check("nostk_cause", 32'(b_cause), 1);
    check("nostk_ss", 32'(b_ss), 0);
    do_reset();

    for (int i = 0; i < 80; i++) begin
      w   = $urandom;
      sel = $urandom_range(0, 39);
      w[31:26] = (sel < 30) ? 6'(sel) : 6'($urandom_range(30, 63));
      run_instr(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), stuck);
      if (stuck) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
